prog_ctr: RTL and testbench

Program counter unit that consumes the signed branch offset (`target`) produced by the branch-target LUT. Each cycle it either advances the PC by 1, applies a relative branch (PC + target), or jumps absolute. A start/done handshake frames program execution, and a retired-instruction counter runs alongside the PC. The block sits between the control decoder and instruction ROM address input.

---
 rtl/prog_ctr.sv | 87 ++++++++
 tb/tb_prog_ctr.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prog_ctr.sv
// Program counter with start/done framing: sequential advance, relative branch,
// absolute jump and halt, plus a saturating retired-instruction counter.
module prog_ctr #(
  parameter int              D          = 12,
  parameter int              CW         = 16,
  parameter logic [D-1:0]    START_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_en,
  input  logic                branch_cond,
  input  logic signed [D-1:0] target,
  input  logic                jump_en,
  input  logic [D-1:0]        jump_addr,
  input  logic                halt,
  output logic [D-1:0]        pc,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       instr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [D-1:0]    pc_nxt;
  logic [CW-1:0]   cnt_nxt;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (&c) return c;
    return c + CW'(1);
  endfunction

  // Relative target is two's complement; the D-bit add drops the carry.
  function automatic logic [D-1:0] rel_add(input logic [D-1:0] base,
                                           input logic signed [D-1:0] ofs);
    return base + $unsigned(ofs);
  endfunction

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = instr_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_nxt    = START_ADDR;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_nxt = sat_inc(instr_cnt);
          if (halt)
            state_nxt = DONE;
          else if (jump_en)
            pc_nxt = jump_addr;
          else if (branch_en && branch_cond)
            pc_nxt = rel_add(pc, target);
          else
            pc_nxt = pc + D'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= START_ADDR;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_cnt <= cnt_nxt;
    end
  end

  // Status flags decode straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr (D=12, CW=4) with hand-computed expectations.
module tb_prog_ctr;

  localparam int D  = 12;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, stall, branch_en, branch_cond, jump_en, halt;
  logic signed [D-1:0] target;
  logic [D-1:0]        jump_addr;
  logic [D-1:0]        pc;
  logic                busy, done;
  logic [CW-1:0]       instr_cnt;

  int vectors     = 0;
  int miscompares = 0;

  prog_ctr #(.D(D), .CW(CW), .START_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_cond(branch_cond), .target(target),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .pc(pc), .busy(busy), .done(done), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp_pc, input int exp_cnt,
                             input logic exp_busy, input logic exp_done);
    check({tag, ".pc"},   32'(pc),        32'(exp_pc));
    check({tag, ".cnt"},  32'(instr_cnt), 32'(exp_cnt));
    check({tag, ".busy"}, 32'(busy),      32'(exp_busy));
    check({tag, ".done"}, 32'(done),      32'(exp_done));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_cond = 1'b0;
    jump_en = 1'b0; halt = 1'b0; target = '0; jump_addr = '0;

    // Reset state
    tick(); tick();
    check_state("reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    jump_en = 1'b1; jump_addr = 12'd77; halt = 1'b1;
    tick();
    check_state("idle_ignore", 0, 0, 1'b0, 1'b0);
    jump_en = 1'b0; halt = 1'b0;

    // Sequential fetch with stall: 0,1,2,3,3,3,4
    start = 1'b1; tick(); start = 1'b0;
    check_state("seq0", 0, 0, 1'b1, 1'b0);
    tick(); check_state("seq1", 1, 1, 1'b1, 1'b0);
    tick(); check_state("seq2", 2, 2, 1'b1, 1'b0);
    tick(); check_state("seq3", 3, 3, 1'b1, 1'b0);
    stall = 1'b1;
    tick(); check_state("stall1", 3, 3, 1'b1, 1'b0);
    tick(); check_state("stall2", 3, 3, 1'b1, 1'b0);
    stall = 1'b0;
    tick(); check_state("seq4", 4, 4, 1'b1, 1'b0);

    // Start during RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    check_state("start_in_run", 5, 5, 1'b1, 1'b0);

    // Reset mid-RUN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_state("rst_midrun", 0, 0, 1'b0, 1'b0);
    tick();
    check_state("rst_idle", 0, 0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check_state("restart", 0, 0, 1'b1, 1'b0);

    // Relative branches
    jump_en = 1'b1; jump_addr = 12'd50; tick(); jump_en = 1'b0;
    check_state("jmp50", 50, 1, 1'b1, 1'b0);
    branch_en = 1'b1; branch_cond = 1'b1; target = -12'sd41;
    tick(); check_state("br_neg", 9, 2, 1'b1, 1'b0);
    target = 12'sd31;
    tick(); check_state("br_pos", 40, 3, 1'b1, 1'b0);
    branch_cond = 1'b0;
    tick(); check_state("br_nottaken", 41, 4, 1'b1, 1'b0);
    branch_cond = 1'b1; target = 12'sd0;
    tick(); check_state("br_self", 41, 5, 1'b1, 1'b0);
    branch_en = 1'b0; branch_cond = 1'b0;

    // Wrap-around both directions
    jump_en = 1'b1; jump_addr = 12'd4; tick(); jump_en = 1'b0;
    check_state("jmp4", 4, 6, 1'b1, 1'b0);
    branch_en = 1'b1; branch_cond = 1'b1; target = -12'sd5;
    tick(); check_state("wrap_neg", 4095, 7, 1'b1, 1'b0);
    branch_en = 1'b0; branch_cond = 1'b0;
    tick(); check_state("wrap_inc", 0, 8, 1'b1, 1'b0);

    // Jump beats taken branch
    jump_en = 1'b1; jump_addr = 12'd300; branch_en = 1'b1; branch_cond = 1'b1; target = 12'sd10;
    tick(); check_state("jmp_over_br", 300, 9, 1'b1, 1'b0);
    branch_en = 1'b0; branch_cond = 1'b0;
    jump_addr = 12'd7; tick(); jump_en = 1'b0;
    check_state("jmp7", 7, 10, 1'b1, 1'b0);

    // Halt beats jump and branch
    halt = 1'b1; jump_en = 1'b1; jump_addr = 12'd100;
    branch_en = 1'b1; branch_cond = 1'b1; target = 12'sd10;
    tick();
    halt = 1'b0; jump_en = 1'b0; branch_en = 1'b0; branch_cond = 1'b0;
    check_state("halt", 7, 11, 1'b0, 1'b1);
    tick(); check_state("done_hold", 7, 11, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_state("done_restart", 0, 0, 1'b1, 1'b0);

    // Counter saturation at 15 while pc keeps advancing
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 16 || k == 20)
        check_state($sformatf("sat%0d", k), k, (k > 15) ? 15 : k, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
